// File: rtl/tdm_mac_if.sv
// tdm_mac_if: frame handshake and packed channel buses for tdm_mac.
//
// Handshake: the master raises start for one or more cycles. The unit
// accepts it only while busy=0. busy stays high from the accepting edge
// until the edge that raises done. done is a single-cycle pulse, and
// products/overflows change on that same edge. start pulses that arrive
// while busy=1 are dropped, not queued.
interface tdm_mac_if #(
  parameter int C_WIDTH   = 32,
  parameter int NUM_UNITS = 8
) ();
  logic [C_WIDTH*NUM_UNITS-1:0] multiplicands;
  logic [C_WIDTH*NUM_UNITS-1:0] multipliers;
  logic [C_WIDTH*NUM_UNITS-1:0] addends;
  logic                         start;
  logic                         busy;
  logic                         done;
  logic [C_WIDTH*NUM_UNITS-1:0] products;
  logic [NUM_UNITS-1:0]         overflows;

  modport master (
    output multiplicands, multipliers, addends, start,
    input  busy, done, products, overflows
  );

  modport slave (
    input  multiplicands, multipliers, addends, start,
    output busy, done, products, overflows
  );
endinterface

// File: rtl/tdm_mac.sv
// tdm_mac: time-division-multiplexed multiply-accumulate.
// For each channel i it computes products[i] = a[i]*b[i] + c[i] with one
// shared shift-add multiplier. Each channel takes C_WIDTH+1 cycles, and a
// frame takes NUM_UNITS*(C_WIDTH+1)+1 cycles.
// Optional macro TDM_MAC_SAT_EN: channels that overflow commit all-ones
// instead of the value wrapped modulo 2^C_WIDTH.
// state_dbg exposes the FSM state: 0=IDLE 1=LOAD 2=MUL 3=COMMIT.
module tdm_mac #(
  parameter int C_WIDTH   = 32,
  parameter int NUM_UNITS = 8
) (
  input  logic       ctl_clk,
  input  logic       ctl_rst,
  tdm_mac_if.slave   bus,
  output logic [1:0] state_dbg
);

  localparam int AW = 2*C_WIDTH + 1;
  localparam int MW = 2*C_WIDTH;
  localparam int CW = $clog2(C_WIDTH);
  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(C_WIDTH - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_UNITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL, S_COMMIT} state_t;

  state_t                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [AW-1:0]                acc_q, acc_d;
  logic [MW-1:0]                mcand_q, mcand_d;
  logic [C_WIDTH-1:0]           mplier_q, mplier_d;
  logic [C_WIDTH-1:0]           op_a_q [NUM_UNITS];
  logic [C_WIDTH-1:0]           op_a_d [NUM_UNITS];
  logic [C_WIDTH-1:0]           op_b_q [NUM_UNITS];
  logic [C_WIDTH-1:0]           op_b_d [NUM_UNITS];
  logic [C_WIDTH-1:0]           op_c_q [NUM_UNITS];
  logic [C_WIDTH-1:0]           op_c_d [NUM_UNITS];
  logic [C_WIDTH-1:0]           shadow_q [NUM_UNITS];
  logic [C_WIDTH-1:0]           shadow_d [NUM_UNITS];
  logic [NUM_UNITS-1:0]         shadow_ovf_q, shadow_ovf_d;
  logic [C_WIDTH*NUM_UNITS-1:0] products_q, products_d;
  logic [NUM_UNITS-1:0]         overflows_q, overflows_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [AW-1:0]                sum;
  logic                         sum_ovf;

  // Next-state logic for the FSM and the shift-add datapath.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_c_d       = op_c_q;
    shadow_d     = shadow_q;
    shadow_ovf_d = shadow_ovf_q;
    products_d   = products_q;
    overflows_d  = overflows_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    // This add includes the current cycle's partial product, so on the
    // last MUL cycle sum already holds the finished result.
    sum     = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : AW'(0));
    sum_ovf = |sum[AW-1:C_WIDTH];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < NUM_UNITS; i++) begin
            op_a_d[i] = bus.multiplicands[i*C_WIDTH +: C_WIDTH];
            op_b_d[i] = bus.multipliers[i*C_WIDTH +: C_WIDTH];
            op_c_d[i] = bus.addends[i*C_WIDTH +: C_WIDTH];
          end
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d    = {{(C_WIDTH+1){1'b0}}, op_c_q[idx_q]};
        mcand_d  = {{C_WIDTH{1'b0}}, op_a_q[idx_q]};
        mplier_d = op_b_q[idx_q];
        cnt_d    = '0;
        state_d  = S_MUL;
      end
      S_MUL: begin
        acc_d    = sum;
        mcand_d  = {mcand_q[MW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[C_WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
`ifdef TDM_MAC_SAT_EN
          shadow_d[idx_q] = sum_ovf ? {C_WIDTH{1'b1}} : sum[C_WIDTH-1:0];
`else
          shadow_d[idx_q] = sum[C_WIDTH-1:0];
`endif
          shadow_ovf_d[idx_q] = sum_ovf;
          if (idx_q == LAST_IDX) begin
            state_d = S_COMMIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < NUM_UNITS; i++) begin
          products_d[i*C_WIDTH +: C_WIDTH] = shadow_q[i];
        end
        overflows_d = shadow_ovf_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register. Reset aborts any frame in flight and clears every result.
  always_ff @(posedge ctl_clk) begin
    if (ctl_rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        op_a_q[i]   <= '0;
        op_b_q[i]   <= '0;
        op_c_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      shadow_ovf_q <= '0;
      products_q   <= '0;
      overflows_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_c_q       <= op_c_d;
      shadow_q     <= shadow_d;
      shadow_ovf_q <= shadow_ovf_d;
      products_q   <= products_d;
      overflows_q  <= overflows_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.products  = products_q;
  assign bus.overflows = overflows_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_tdm_mac.sv
// tb_tdm_mac: directed frames for tdm_mac. The expected results are
// queued when each frame starts, and a monitor compares them when done
// pulses.
module tb_tdm_mac;

  localparam int W   = 32;
  localparam int N   = 8;
  localparam int LAT = N*(W+1) + 1;

  // Clock and reset.
  logic ctl_clk = 1'b0;
  logic ctl_rst = 1'b1;
  logic [1:0] state_dbg;
  int unsigned cyc = 0;

  always #5 ctl_clk = ~ctl_clk;
  always @(posedge ctl_clk) cyc <= cyc + 1;

  tdm_mac_if #(.C_WIDTH(W), .NUM_UNITS(N)) bus_if ();

  tdm_mac #(.C_WIDTH(W), .NUM_UNITS(N)) dut (
    .ctl_clk   (ctl_clk),
    .ctl_rst   (ctl_rst),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  // Scoreboard state.
  typedef struct packed {
    logic [W*N-1:0] prod;
    logic [N-1:0]   ovf;
    logic [31:0]    due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int applied     = 0;
  int miscompares = 0;
  int dones       = 0;

  logic [W*N-1:0] ep;
  logic [N-1:0]   eo;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: when done pulses, pop the oldest expected frame and compare it.
  always @(negedge ctl_clk) begin
    if (bus_if.done === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_done: done pulse at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < N; i++)
          check($sformatf("products[%0d]", i), 64'(bus_if.products[i*W +: W]), 64'(mon_e.prod[i*W +: W]));
        check("overflows", 64'(bus_if.overflows), 64'(mon_e.ovf));
        check("done_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  // Driver tasks.
  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.multiplicands = '0;
    bus_if.multipliers   = '0;
    bus_if.addends       = '0;
    bus_if.start         = 1'b0;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    bus_if.multiplicands[i*W +: W] = a;
    bus_if.multipliers[i*W +: W]   = b;
    bus_if.addends[i*W +: W]       = c;
  endtask

  task automatic exp_clear();
    ep = '0;
    eo = '0;
  endtask

  task automatic exp_ch(input int i, input logic [W-1:0] p, input logic o);
    ep[i*W +: W] = p;
    eo[i]        = o;
  endtask

  task automatic push_exp(input int unsigned due);
    exp_t e;
    e.prod = ep;
    e.ovf  = eo;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  task automatic start_frame(output int unsigned s);
    bus_if.start = 1'b1;
    tick();
    s = cyc;
    bus_if.start = 1'b0;
  endtask

  // Wait until the monitor has seen `target` done pulses. When chk_busy is
  // set, busy must stay high until then.
  task automatic wait_done(input int target, input int budget, input bit chk_busy, input string name);
    int t = 0;
    int busy_bad = 0;
    while (dones < target && t < budget) begin
      @(negedge ctl_clk);
      #1;
      if (dones < target && bus_if.busy !== 1'b1) busy_bad++;
      t++;
    end
    check({name, "_done_seen"}, 64'(dones >= target), 64'd1);
    if (chk_busy) check({name, "_busy_held"}, 64'(busy_bad), 64'd0);
  endtask

  task automatic basic_inputs();
    clear_inputs();
    set_ch(0, 32'd1234, 32'd5678, 32'd99);
    set_ch(7, 32'd65535, 32'd65535, 32'd0);
  endtask

  task automatic basic_exp();
    exp_clear();
    exp_ch(0, 32'd7006751, 1'b0);
    exp_ch(7, 32'd4294836225, 1'b0);
  endtask

  logic [W-1:0] dvd [N] = '{32'h7FFFFFFF, 32'd1000000007, 32'd12345, 32'd0,
                            32'h40000000, 32'd999, 32'd65536, 32'd31415926};
  logic [W-1:0] dvs [N] = '{32'd7, 32'd13, 32'd1, 32'd5,
                            32'h40000000, 32'd1000, 32'd3, 32'd271828};

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int unsigned s;
    int exp_dones;
    exp_dones = 0;
    clear_inputs();
    ctl_rst = 1'b1;
    repeat (3) tick();
    ctl_rst = 1'b0;

    // Reset state.
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    check("rst_products", 64'(|bus_if.products), 64'd0);
    check("rst_overflows", 64'(bus_if.overflows), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // Basic frame.
    basic_inputs();
    start_frame(s);
    basic_exp();
    push_exp(s + LAT);
    exp_dones++;
    wait_done(exp_dones, LAT + 20, 1'b1, "basic");
    tick();

    // Overflow: 0xFFFFFFFF*2+5 = 0x2_00000003.
    clear_inputs();
    set_ch(3, 32'hFFFFFFFF, 32'd2, 32'd5);
    start_frame(s);
    exp_clear();
`ifdef TDM_MAC_SAT_EN
    exp_ch(3, 32'hFFFFFFFF, 1'b1);
`else
    exp_ch(3, 32'h00000003, 1'b1);
`endif
    push_exp(s + LAT);
    exp_dones++;
    wait_done(exp_dones, LAT + 20, 1'b1, "overflow");
    tick();

    // Edge operands: zero multiplicand, zero multiplier, 1*1+max.
    clear_inputs();
    set_ch(0, 32'd0, 32'd77, 32'd5);
    set_ch(1, 32'd123, 32'd0, 32'd9);
    set_ch(2, 32'd1, 32'd1, 32'hFFFFFFFF);
    start_frame(s);
    exp_clear();
    exp_ch(0, 32'd5, 1'b0);
    exp_ch(1, 32'd9, 1'b0);
`ifdef TDM_MAC_SAT_EN
    exp_ch(2, 32'hFFFFFFFF, 1'b1);
`else
    exp_ch(2, 32'd0, 1'b1);
`endif
    push_exp(s + LAT);
    exp_dones++;
    wait_done(exp_dones, LAT + 20, 1'b1, "edge");
    tick();

    // Divider loopback: quotient*divisor+remainder reproduces the dividend.
    clear_inputs();
    exp_clear();
    for (int i = 0; i < N; i++) begin
      set_ch(i, dvd[i] / dvs[i], dvs[i], dvd[i] % dvs[i]);
      exp_ch(i, dvd[i], 1'b0);
    end
    start_frame(s);
    push_exp(s + LAT);
    exp_dones++;
    wait_done(exp_dones, LAT + 20, 1'b1, "loopback");
    tick();

    // Snapshot: inputs scrambled after 10 cycles, stray start at cycle 100.
    basic_inputs();
    start_frame(s);
    basic_exp();
    push_exp(s + LAT);
    exp_dones++;
    repeat (10) tick();
    bus_if.multiplicands = {N{$urandom()}};
    bus_if.multipliers   = {N{$urandom()}};
    bus_if.addends       = {N{$urandom()}};
    while (cyc < s + 99) tick();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    wait_done(exp_dones, LAT + 20, 1'b1, "snapshot");
    repeat (50) tick();

    // Reset mid-frame: the partial frame is never committed.
    basic_inputs();
    start_frame(s);
    while (cyc < s + 149) tick();
    ctl_rst = 1'b1;
    tick();
    ctl_rst = 1'b0;
    check("midrst_busy", 64'(bus_if.busy), 64'd0);
    check("midrst_products", 64'(|bus_if.products), 64'd0);
    check("midrst_overflows", 64'(bus_if.overflows), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'd0);

    // Reset and start together: start is not captured.
    ctl_rst      = 1'b1;
    bus_if.start = 1'b1;
    tick();
    ctl_rst      = 1'b0;
    bus_if.start = 1'b0;
    tick();
    check("rst_start_busy", 64'(bus_if.busy), 64'd0);
    check("rst_start_state", 64'(state_dbg), 64'd0);
    repeat (LAT + 20) tick();

    // Fresh frame after reset.
    basic_inputs();
    start_frame(s);
    basic_exp();
    push_exp(s + LAT);
    exp_dones++;
    wait_done(exp_dones, LAT + 20, 1'b1, "fresh");
    tick();

    // Back-to-back: start held high gives one frame every LAT+1 cycles.
    basic_inputs();
    bus_if.start = 1'b1;
    tick();
    s = cyc;
    basic_exp();
    push_exp(s + LAT);
    push_exp(s + LAT + 1 + LAT);
    exp_dones += 2;
    wait_done(exp_dones, 2*LAT + 40, 1'b0, "b2b");
    bus_if.start = 1'b0;
    repeat (LAT + 20) tick();

    check("done_count", 64'(dones), 64'(exp_dones));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
